// File: rtl/ps2_line_writer.sv
// PS/2 keyboard to 16x128-bit text-line RAM writer: decodes set-2 make codes and commits 16-char lines.
// Optional PARITY_CHECK_EN: frames additionally require odd parity over data+parity bits.
module ps2_line_writer #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ps2c,
  input  logic         ps2d,
  output logic         we,
  output logic [3:0]   addr_in,
  output logic [127:0] din,
  output logic [3:0]   col,
  output logic         rx_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [127:0] BLANK = {16{8'h20}};

  typedef enum logic [1:0] {F_IDLE, F_SHIFT, F_CHECK} fstate_t;
  typedef enum logic [1:0] {L_EDIT, L_WRITE, L_CLEAR} lstate_t;

  logic [1:0]    c_sync, d_sync;
  logic          c_filt, tick;
  logic [FW-1:0] f_cnt;

  fstate_t       fstate;
  logic [3:0]    bit_cnt;
  logic [9:0]    sr;
  logic [TW-1:0] t_cnt;
  logic [7:0]    code;
  logic          code_rdy;
  logic          frame_ok;

  lstate_t       lstate;
  logic          brk, ext;
  logic          pend_v;
  logic [7:0]    pend_code;
  logic          cur_v;
  logic [7:0]    cur_code;
  logic [8:0]    key;

  // Set-2 make code to ASCII; bit 8 flags a printable key.
  function automatic logic [8:0] to_ascii(input logic [7:0] c);
    case (c)
      8'h1C: return 9'h141; 8'h32: return 9'h142; 8'h21: return 9'h143; 8'h23: return 9'h144;
      8'h24: return 9'h145; 8'h2B: return 9'h146; 8'h34: return 9'h147; 8'h33: return 9'h148;
      8'h43: return 9'h149; 8'h3B: return 9'h14A; 8'h42: return 9'h14B; 8'h4B: return 9'h14C;
      8'h3A: return 9'h14D; 8'h31: return 9'h14E; 8'h44: return 9'h14F; 8'h4D: return 9'h150;
      8'h15: return 9'h151; 8'h2D: return 9'h152; 8'h1B: return 9'h153; 8'h2C: return 9'h154;
      8'h3C: return 9'h155; 8'h2A: return 9'h156; 8'h1D: return 9'h157; 8'h22: return 9'h158;
      8'h35: return 9'h159; 8'h1A: return 9'h15A;
      8'h45: return 9'h130; 8'h16: return 9'h131; 8'h1E: return 9'h132; 8'h26: return 9'h133;
      8'h25: return 9'h134; 8'h2E: return 9'h135; 8'h36: return 9'h136; 8'h3D: return 9'h137;
      8'h3E: return 9'h138; 8'h46: return 9'h139;
      8'h29: return 9'h120;
      default: return 9'h000;
    endcase
  endfunction

  // Column k lives at bits [127-8k -: 8].
  function automatic logic [127:0] set_char(input logic [127:0] line, input logic [3:0] k,
                                            input logic [7:0] ch);
    logic [127:0] r;
    r = line;
    for (int i = 0; i < 16; i++)
      if (k == 4'(i)) r[127-8*i -: 8] = ch;
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_sync <= 2'b11;
      d_sync <= 2'b11;
    end else begin
      c_sync <= {c_sync[0], ps2c};
      d_sync <= {d_sync[0], ps2d};
    end
  end

  // Level changes only after FILTER_LEN consecutive samples disagree with it; falling edge -> tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_filt <= 1'b1;
      f_cnt  <= '0;
      tick   <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (c_sync[1] == c_filt) begin
        f_cnt <= '0;
      end else if (f_cnt == FW'(FILTER_LEN - 1)) begin
        c_filt <= c_sync[1];
        f_cnt  <= '0;
        tick   <= c_filt;
      end else begin
        f_cnt <= f_cnt + FW'(1);
      end
    end
  end

`ifdef PARITY_CHECK_EN
  assign frame_ok = sr[9] & (^sr[8:0]);
`else
  assign frame_ok = sr[9];
`endif

  // Frame receiver: start bit, 8 data LSB first, parity, stop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fstate   <= F_IDLE;
      bit_cnt  <= '0;
      sr       <= '0;
      t_cnt    <= '0;
      code     <= '0;
      code_rdy <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      code_rdy <= 1'b0;
      rx_err   <= 1'b0;
      case (fstate)
        F_IDLE: begin
          t_cnt <= '0;
          if (tick && !d_sync[1]) begin
            fstate  <= F_SHIFT;
            bit_cnt <= '0;
          end
        end
        F_SHIFT: begin
          if (tick) begin
            sr    <= {d_sync[1], sr[9:1]};
            t_cnt <= '0;
            if (bit_cnt == 4'd9) fstate <= F_CHECK;
            else                 bit_cnt <= bit_cnt + 4'd1;
          end else if (t_cnt == TW'(TIMEOUT_CYC - 1)) begin
            fstate <= F_IDLE;
            rx_err <= 1'b1;
          end else begin
            t_cnt <= t_cnt + TW'(1);
          end
        end
        F_CHECK: begin
          if (frame_ok) begin
            code     <= sr[7:0];
            code_rdy <= 1'b1;
          end else begin
            rx_err <= 1'b1;
          end
          fstate <= F_IDLE;
        end
        default: fstate <= F_IDLE;
      endcase
    end
  end

  assign cur_v    = pend_v | code_rdy;
  assign cur_code = pend_v ? pend_code : code;
  assign key      = to_ascii(cur_code);

  // Line editor and commit sequencer; codes arriving mid-commit wait in the pending slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lstate    <= L_EDIT;
      brk       <= 1'b0;
      ext       <= 1'b0;
      pend_v    <= 1'b0;
      pend_code <= '0;
      we        <= 1'b0;
      din       <= BLANK;
      col       <= '0;
      addr_in   <= '0;
    end else begin
      we <= 1'b0;
      case (lstate)
        L_EDIT: begin
          if (pend_v) begin
            pend_v <= code_rdy;
            if (code_rdy) pend_code <= code;
          end
          if (cur_v) begin
            if (brk) begin
              brk <= 1'b0;
            end else if (ext) begin
              ext <= 1'b0;
            end else if (cur_code == 8'hF0) begin
              brk <= 1'b1;
            end else if (cur_code == 8'hE0) begin
              ext <= 1'b1;
            end else if (cur_code == 8'h66) begin
              if (col != 4'd0) begin
                col <= col - 4'd1;
                din <= set_char(din, col - 4'd1, 8'h20);
              end
            end else if (cur_code == 8'h5A) begin
              lstate <= L_WRITE;
              we     <= 1'b1;
            end else if (key[8]) begin
              din <= set_char(din, col, key[7:0]);
              if (col == 4'd15) begin
                lstate <= L_WRITE;
                we     <= 1'b1;
              end else begin
                col <= col + 4'd1;
              end
            end
          end
        end
        L_WRITE: begin
          if (code_rdy) begin
            pend_v    <= 1'b1;
            pend_code <= code;
          end
          lstate <= L_CLEAR;
        end
        L_CLEAR: begin
          if (code_rdy) begin
            pend_v    <= 1'b1;
            pend_code <= code;
          end
          din     <= BLANK;
          col     <= '0;
          addr_in <= addr_in + 4'd1;
          lstate  <= L_EDIT;
        end
        default: lstate <= L_EDIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_line_writer.sv
// Directed bench for ps2_line_writer: drives PS/2 frames and checks committed lines and error pulses.
module tb_ps2_line_writer;

  localparam int unsigned TMO = 2000;
  localparam logic [127:0] BLANK = {16{8'h20}};

  logic         clk = 1'b0;
  logic         reset;
  logic         ps2c;
  logic         ps2d;
  logic         we;
  logic [3:0]   addr_in;
  logic [127:0] din;
  logic [3:0]   col;
  logic         rx_err;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int rx_cnt = 0;
  logic [3:0]   cap_addr [0:31];
  logic [127:0] cap_din  [0:31];

  ps2_line_writer #(.FILTER_LEN(8), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d),
    .we(we), .addr_in(addr_in), .din(din), .col(col), .rx_err(rx_err)
  );

  always #5 clk = ~clk;

  // Record every cycle with we or rx_err high.
  always @(negedge clk) begin
    if (we) begin
      if (we_cnt < 32) begin
        cap_addr[we_cnt] <= addr_in;
        cap_din[we_cnt]  <= din;
      end
      we_cnt <= we_cnt + 1;
    end
    if (rx_err) rx_cnt <= rx_cnt + 1;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sends the first nbits of {stop, parity, code, start}; bad_par flips the odd parity bit.
  task automatic send_frame(input logic [7:0] c, input logic stop_b, input logic bad_par,
                            input int nbits);
    logic [10:0] bits;
    bits = {stop_b, (~^c) ^ bad_par, c, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2d = bits[i];
      repeat (10) @(posedge clk);
      ps2c = 1'b0;
      repeat (20) @(posedge clk);
      ps2c = 1'b1;
      repeat (10) @(posedge clk);
    end
    ps2d = 1'b1;
    repeat (60) @(posedge clk);
  endtask

  task automatic key(input logic [7:0] c);
    send_frame(c, 1'b1, 1'b0, 11);
  endtask

  int base;
  int rx0;

  initial begin
    reset = 1'b1;
    ps2c  = 1'b1;
    ps2d  = 1'b1;
    repeat (5) @(posedge clk);
    reset = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("reset_we_cnt", 128'(we_cnt), 128'(0));
    check("reset_addr", 128'(addr_in), 128'(0));
    check("reset_col", 128'(col), 128'(0));
    check("reset_din", din, BLANK);
    check("reset_rx", 128'(rx_cnt), 128'(0));

    // 'A' with break codes, then enter
    key(8'h1C);
    @(negedge clk);
    check("a_col", 128'(col), 128'(1));
    check("a_din", din, {8'h41, {15{8'h20}}});
    key(8'hF0); key(8'h1C); key(8'h5A); key(8'hF0); key(8'h5A);
    @(negedge clk);
    check("enter_we_cnt", 128'(we_cnt), 128'(1));
    check("enter_addr", 128'(cap_addr[0]), 128'(0));
    check("enter_din", cap_din[0], {8'h41, {15{8'h20}}});
    check("enter_next_addr", 128'(addr_in), 128'(1));
    check("enter_next_col", 128'(col), 128'(0));
    check("enter_next_din", din, BLANK);

    // 16 x '1' auto-commits
    for (int i = 0; i < 15; i++) key(8'h16);
    @(negedge clk);
    check("full15_col", 128'(col), 128'(15));
    check("full15_we_cnt", 128'(we_cnt), 128'(1));
    key(8'h16);
    @(negedge clk);
    check("auto_we_cnt", 128'(we_cnt), 128'(2));
    check("auto_addr", 128'(cap_addr[1]), 128'(1));
    check("auto_din", cap_din[1], {16{8'h31}});
    check("auto_col", 128'(col), 128'(0));
    check("auto_next_addr", 128'(addr_in), 128'(2));

    // Backspace erases 'S'
    key(8'h1C); key(8'h1B); key(8'h66);
    @(negedge clk);
    check("bs_col", 128'(col), 128'(1));
    check("bs_din", din, {8'h41, {15{8'h20}}});
    key(8'h5A);
    @(negedge clk);
    check("bs_we_cnt", 128'(we_cnt), 128'(3));
    check("bs_addr", 128'(cap_addr[2]), 128'(2));
    check("bs_line", cap_din[2], {8'h41, {15{8'h20}}});
    key(8'h66);
    @(negedge clk);
    check("bs0_col", 128'(col), 128'(0));
    check("bs0_din", din, BLANK);
    check("bs0_we_cnt", 128'(we_cnt), 128'(3));

    // Row wrap: reset, then 17 enters
    reset = 1'b1;
    repeat (3) @(posedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst2_addr", 128'(addr_in), 128'(0));
    base = we_cnt;
    for (int i = 0; i < 17; i++) key(8'h5A);
    @(negedge clk);
    check("wrap_we_cnt", 128'(we_cnt), 128'(base + 17));
    for (int i = 0; i < 17; i++)
      check($sformatf("wrap_addr%0d", i), 128'(cap_addr[base + i]), 128'(i % 16));
    check("wrap_final_addr", 128'(addr_in), 128'(1));

    // Bad stop bit
    rx0 = rx_cnt;
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    @(negedge clk);
    check("stop_rx", 128'(rx_cnt), 128'(rx0 + 1));
    check("stop_col", 128'(col), 128'(0));
    check("stop_din", din, BLANK);

    // Truncated frame times out, then a good frame still decodes
    send_frame(8'h1C, 1'b1, 1'b0, 4);
    repeat (TMO - 200) @(posedge clk);
    @(negedge clk);
    check("tmo_early_rx", 128'(rx_cnt), 128'(rx0 + 1));
    repeat (400) @(posedge clk);
    @(negedge clk);
    check("tmo_rx", 128'(rx_cnt), 128'(rx0 + 2));
    key(8'h1C);
    @(negedge clk);
    check("tmo_next_col", 128'(col), 128'(1));
    check("tmo_next_din", din, {8'h41, {15{8'h20}}});

    // Even-parity frame
    send_frame(8'h1C, 1'b1, 1'b1, 11);
    @(negedge clk);
`ifdef PARITY_CHECK_EN
    check("par_rx", 128'(rx_cnt), 128'(rx0 + 3));
    check("par_col", 128'(col), 128'(1));
    check("par_din", din, {8'h41, {15{8'h20}}});
`else
    check("par_rx", 128'(rx_cnt), 128'(rx0 + 2));
    check("par_col", 128'(col), 128'(2));
    check("par_din", din, {8'h41, 8'h41, {14{8'h20}}});
`endif
    check("final_we_cnt", 128'(we_cnt), 128'(base + 17));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
